// File: rtl/f1_pkg.sv
// Shared types for the starting-lights block: sequencer state encoding and default lamp count.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STEP_TRIG,
    STEP_WAIT,
    HOLD_TRIG,
    HOLD_WAIT,
    GO,
    FAULT
  } seq_state_t;

  localparam int NUM_LIGHTS_DEFAULT = 5;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the history bit resets high so a level held through reset is not an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) prev <= 1'b1;
    else      prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/light_sequencer.sv
// Starting-lights sequencer: steps the lamps through the delay timer, then a random hold before go.
// Optional false-start detection is enabled with `define LIGHT_SEQ_FALSE_START_EN.
module light_sequencer
  import f1_pkg::*;
#(
  parameter int WIDTH      = 14,
  parameter int NUM_LIGHTS = NUM_LIGHTS_DEFAULT,
  parameter int STEP_N     = 10000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      rand_n,
  input  logic                  time_out,
  output logic                  trigger,
  output logic [WIDTH-1:0]      N,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  go,
  output logic                  busy
`ifdef LIGHT_SEQ_FALSE_START_EN
  ,
  input  logic                  react,
  output logic                  false_start
`endif
);

  localparam int               CNT_W    = $clog2(NUM_LIGHTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LIGHTS);
  localparam logic [WIDTH-1:0] STEP_VAL = WIDTH'(STEP_N);

  seq_state_t       state;
  logic [CNT_W-1:0] light_cnt;
  logic [WIDTH-1:0] hold_n;
  logic [WIDTH-1:0] hold_val;
  logic             start_rise;

  rise_detect u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (start),
    .rise (start_rise)
  );

`ifdef LIGHT_SEQ_FALSE_START_EN
  logic react_rise;
  logic in_sequence;

  rise_detect u_react_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (react),
    .rise (react_rise)
  );

  assign in_sequence = (state == STEP_TRIG) || (state == STEP_WAIT) ||
                       (state == HOLD_TRIG) || (state == HOLD_WAIT);
`endif

  // A zero count would make the delay timer wrap to its maximum, so clamp it to one.
  assign hold_val = (rand_n == '0) ? WIDTH'(1) : rand_n;

  function automatic logic [NUM_LIGHTS-1:0] therm(input logic [CNT_W-1:0] cnt);
    logic [NUM_LIGHTS-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) t[i] = (i < int'(cnt));
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      light_cnt   <= '0;
      hold_n      <= WIDTH'(1);
      trigger     <= 1'b0;
      go          <= 1'b0;
      busy        <= 1'b0;
      lights      <= '0;
`ifdef LIGHT_SEQ_FALSE_START_EN
      false_start <= 1'b0;
`endif
    end else begin
      trigger <= 1'b0;
      go      <= 1'b0;
`ifdef LIGHT_SEQ_FALSE_START_EN
      if (react_rise && in_sequence) begin
        state       <= FAULT;
        lights      <= '0;
        false_start <= 1'b1;
      end else
`endif
      case (state)
        IDLE: begin
          if (start_rise) begin
            state     <= STEP_TRIG;
            light_cnt <= CNT_W'(1);
            lights    <= therm(CNT_W'(1));
            trigger   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        STEP_TRIG: state <= STEP_WAIT;
        STEP_WAIT: begin
          if (time_out) begin
            trigger <= 1'b1;
            if (light_cnt == LAST_CNT) begin
              hold_n <= hold_val;
              lights <= '1;
              state  <= HOLD_TRIG;
            end else begin
              light_cnt <= light_cnt + CNT_W'(1);
              lights    <= therm(light_cnt + CNT_W'(1));
              state     <= STEP_TRIG;
            end
          end
        end
        HOLD_TRIG: state <= HOLD_WAIT;
        HOLD_WAIT: begin
          if (time_out) begin
            state  <= GO;
            go     <= 1'b1;
            lights <= '0;
          end
        end
        GO: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`ifdef LIGHT_SEQ_FALSE_START_EN
        FAULT: begin
          if (start_rise) begin
            state       <= IDLE;
            busy        <= 1'b0;
            false_start <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          lights <= '0;
        end
      endcase
    end
  end

  // N is held for the whole timer handshake because it is a pure decode of registered state.
  assign N = ((state == HOLD_TRIG) || (state == HOLD_WAIT)) ? hold_n : STEP_VAL;

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer with a behavioural delay-timer responder and timeline model.
module tb_light_sequencer;

  localparam int WIDTH  = 14;
  localparam int NL     = 5;
  localparam int STEP_N = 4;
  localparam int P      = STEP_N + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] rand_n = '0;
  logic             time_out = 1'b0;
  logic             trigger;
  logic [WIDTH-1:0] N;
  logic [NL-1:0]    lights;
  logic             go;
  logic             busy;
`ifdef LIGHT_SEQ_FALSE_START_EN
  logic             react = 1'b0;
  logic             false_start;
`endif

  int checks   = 0;
  int failures = 0;

  light_sequencer #(.WIDTH(WIDTH), .NUM_LIGHTS(NL), .STEP_N(STEP_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rand_n   (rand_n),
    .time_out (time_out),
    .trigger  (trigger),
    .N        (N),
    .lights   (lights),
    .go       (go),
    .busy     (busy)
`ifdef LIGHT_SEQ_FALSE_START_EN
    ,
    .react       (react),
    .false_start (false_start)
`endif
  );

  always #5 clk = ~clk;

  // Delay timer stand-in: trigger in cycle c gives time_out in cycle c+N+1; it deliberately ignores
  // rst so a pulse already in flight still arrives after the sequencer is reset.
  int rem    = 0;
  bit active = 1'b0;
  always @(posedge clk) begin
    if (trigger) begin
      rem      = int'(N);
      active   = 1'b1;
      time_out <= 1'b0;
    end else if (active) begin
      rem--;
      if (rem == 0) begin
        time_out <= 1'b1;
        active   = 1'b0;
      end else begin
        time_out <= 1'b0;
      end
    end else begin
      time_out <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full sequence from a start edge at cycle 0; resetAt > 0 pulls rst low in that cycle instead.
  task automatic applyStimulus(input int randVal, input bit toggleStart, input int resetAt);
    int holdN, holdTrig, goCyc, k;
    logic [31:0] expLights;
    bit expTrig;
    holdN    = (randVal == 0) ? 1 : randVal;
    holdTrig = 1 + NL * P;
    goCyc    = holdTrig + holdN + 2;
    rand_n   = WIDTH'(randVal);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= goCyc + 1; c++) begin
      @(negedge clk);
      if (c < holdTrig) begin
        k         = (c - 1) / P + 1;
        expLights = (32'd1 << k) - 32'd1;
        expTrig   = ((c - 1) % P) == 0;
      end else if (c < goCyc) begin
        expLights = (32'd1 << NL) - 32'd1;
        expTrig   = (c == holdTrig);
      end else begin
        expLights = 32'd0;
        expTrig   = 1'b0;
      end
      checkOutput($sformatf("trigger@%0d", c), 32'(trigger), 32'(expTrig));
      checkOutput($sformatf("lights@%0d", c), 32'(lights), expLights);
      checkOutput($sformatf("go@%0d", c), 32'(go), 32'(c == goCyc));
      checkOutput($sformatf("busy@%0d", c), 32'(busy), 32'(c <= goCyc));
      if (c != goCyc)
        checkOutput($sformatf("N@%0d", c), 32'(N),
                    (c >= holdTrig && c < goCyc) ? 32'(holdN) : 32'(STEP_N));
      if (c == resetAt) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rst_lights", 32'(lights), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_trigger", 32'(trigger), 32'd0);
        checkOutput("rst_N", 32'(N), 32'(STEP_N));
        for (int j = 0; j < holdN + 6; j++) begin
          @(negedge clk);
          checkOutput("rst_no_go", 32'(go), 32'd0);
          checkOutput("rst_idle", 32'(busy), 32'd0);
        end
        return;
      end
      if (c >= goCyc - 2) start = 1'b0;
      else if (c == 1 || !toggleStart) start = 1'b0;
      else start = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    $display("[TB] reset check");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_lights", 32'(lights), 32'd0);
    checkOutput("reset_trigger", 32'(trigger), 32'd0);
    checkOutput("reset_go", 32'(go), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_N", 32'(N), 32'(STEP_N));
    rst = 1'b1;

    $display("[TB] directed run rand_n=7");
    applyStimulus(7, 1'b0, 0);
    $display("[TB] clamp run rand_n=0");
    applyStimulus(0, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      int v;
      v = int'($urandom_range(0, 20));
      $display("[TB] random run rand_n=%0d with extra start edges", v);
      applyStimulus(v, 1'b1, 0);
    end

    $display("[TB] start held through reset");
    @(negedge clk); start = 1'b1; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checkOutput("held_start_busy", 32'(busy), 32'd0);
      checkOutput("held_start_trigger", 32'(trigger), 32'd0);
    end
    start = 1'b0;

    $display("[TB] reset during HOLD_WAIT");
    applyStimulus(9, 1'b0, 1 + NL * P + 2);
    repeat (4) @(negedge clk);

`ifdef LIGHT_SEQ_FALSE_START_EN
    $display("[TB] false start");
    rand_n = WIDTH'(5);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("fs_pre_lights", 32'(lights), 32'h7);
    react = 1'b1;
    @(negedge clk);
    checkOutput("fs_flag", 32'(false_start), 32'd1);
    checkOutput("fs_lights", 32'(lights), 32'd0);
    checkOutput("fs_busy", 32'(busy), 32'd1);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      checkOutput("fs_no_go", 32'(go), 32'd0);
      checkOutput("fs_hold_flag", 32'(false_start), 32'd1);
    end
    react = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checkOutput("fs_exit_busy", 32'(busy), 32'd0);
    checkOutput("fs_exit_flag", 32'(false_start), 32'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
